// File: rtl/mawg_cfg_ctrl.sv
// mawg_cfg_ctrl: UART-fed configuration controller for the MAWG waveform
// generator. Received bytes are framed as a command byte followed by four
// data bytes (MSB first) forming a 32-bit word W. A complete, valid frame
// writes one configuration register; command 0x0F clears all of them.
//
// Optional build macro: MAWG_CFG_CHECKSUM_EN adds a sixth byte that must
// equal the XOR of the command and the four data bytes.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   rx_data, rx_busy  UART byte and busy flag (busy 1->0 = byte received)
//   out_sel, wave_sel, freq_ctrl, chirp_*, pulse_duty_cycle, fm_ctr_ctrl,
//   fm_deviation      configuration outputs
//   cfg_update        one-cycle pulse when a valid frame commits
//   frame_err         one-cycle pulse on a rejected or timed-out frame
module mawg_cfg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  output logic [1:0]  out_sel,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_ctrl,
  output logic [31:0] chirp_min_ctrl,
  output logic [31:0] chirp_max_ctrl,
  output logic [31:0] chirp_inc_rate,
  output logic [31:0] chirp_div_rate,
  output logic [31:0] pulse_duty_cycle,
  output logic [31:0] fm_ctr_ctrl,
  output logic        chirp_is_down,
  output logic [3:0]  chirp_delay,
  output logic [4:0]  fm_deviation,
  output logic        cfg_update,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MAWG_CFG_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK} state_t;
  // Whole word must be held while the checksum byte is awaited.
  localparam int unsigned WB = 32;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
  // Only the first three data bytes need storing; the fourth is live.
  localparam int unsigned WB = 24;
`endif

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [WB-1:0]   w_q, w_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            prev_busy_q;
  logic            cfg_update_q, cfg_update_d;
  logic            frame_err_q, frame_err_d;

  logic [1:0]  out_sel_q, out_sel_d, wave_sel_q, wave_sel_d;
  logic [31:0] freq_q, freq_d, cmin_q, cmin_d, cmax_q, cmax_d;
  logic [31:0] cinc_q, cinc_d, cdiv_q, cdiv_d, duty_q, duty_d, fmc_q, fmc_d;
  logic        cdown_q, cdown_d;
  logic [3:0]  cdel_q, cdel_d;
  logic [4:0]  fmdev_q, fmdev_d;

  logic        strobe, timeout, commit;
  logic [31:0] w_word, commit_w;

  assign strobe  = prev_busy_q & ~rx_busy;
  assign timeout = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
`ifdef MAWG_CFG_CHECKSUM_EN
  assign w_word  = {w_q[23:0], rx_data};
`else
  assign w_word  = {w_q, rx_data};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    w_d          = w_q;
    tmo_d        = '0;
`ifdef MAWG_CFG_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    out_sel_d    = out_sel_q;
    wave_sel_d   = wave_sel_q;
    freq_d       = freq_q;
    cmin_d       = cmin_q;
    cmax_d       = cmax_q;
    cinc_d       = cinc_q;
    cdiv_d       = cdiv_q;
    duty_d       = duty_q;
    fmc_d        = fmc_q;
    cdown_d      = cdown_q;
    cdel_d       = cdel_q;
    fmdev_d      = fmdev_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;
    commit       = 1'b0;
    commit_w     = w_word;

    if (timeout) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      frame_err_d = 1'b1;
    end else if ((state_q != S_IDLE) && !strobe) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (strobe) begin
      // A byte arriving on the timeout cycle starts a fresh frame.
      if (timeout || (state_q == S_IDLE)) begin
        state_d = S_DATA;
        cnt_d   = '0;
        cmd_d   = rx_data;
        w_d     = '0;
`ifdef MAWG_CFG_CHECKSUM_EN
        csum_d  = rx_data;
`endif
      end else if (state_q == S_DATA) begin
        w_d = w_word[WB-1:0];
`ifdef MAWG_CFG_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        if (cnt_q == 2'd3) begin
          cnt_d = '0;
`ifdef MAWG_CFG_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
          commit  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`ifdef MAWG_CFG_CHECKSUM_EN
      else begin
        state_d  = S_IDLE;
        commit_w = w_q;
        if (rx_data == csum_q) commit = 1'b1;
        else                   frame_err_d = 1'b1;
      end
`endif
    end

    if (commit) begin
      cfg_update_d = 1'b1;
      case (cmd_q)
        8'h00: out_sel_d  = commit_w[1:0];
        8'h01: wave_sel_d = commit_w[1:0];
        8'h02: freq_d     = commit_w;
        8'h03: cdown_d    = commit_w[0];
        8'h04: cdel_d     = commit_w[3:0];
        8'h05: cmin_d     = commit_w;
        8'h06: cmax_d     = commit_w;
        8'h07: cdiv_d     = commit_w;
        8'h08: cinc_d     = commit_w;
        8'h09: duty_d     = commit_w;
        8'h0A: fmc_d      = commit_w;
        8'h0B: fmdev_d    = commit_w[4:0];
        8'h0F: begin
          out_sel_d  = '0;
          wave_sel_d = '0;
          freq_d     = '0;
          cmin_d     = '0;
          cmax_d     = '0;
          cinc_d     = '0;
          cdiv_d     = '0;
          duty_d     = '0;
          fmc_d      = '0;
          cdown_d    = 1'b0;
          cdel_d     = '0;
          fmdev_d    = '0;
        end
        default: begin
          cfg_update_d = 1'b0;
          frame_err_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      w_q          <= '0;
      tmo_q        <= '0;
`ifdef MAWG_CFG_CHECKSUM_EN
      csum_q       <= '0;
`endif
      prev_busy_q  <= 1'b0;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
      out_sel_q    <= '0;
      wave_sel_q   <= '0;
      freq_q       <= '0;
      cmin_q       <= '0;
      cmax_q       <= '0;
      cinc_q       <= '0;
      cdiv_q       <= '0;
      duty_q       <= '0;
      fmc_q        <= '0;
      cdown_q      <= 1'b0;
      cdel_q       <= '0;
      fmdev_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      w_q          <= w_d;
      tmo_q        <= tmo_d;
`ifdef MAWG_CFG_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      prev_busy_q  <= rx_busy;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
      out_sel_q    <= out_sel_d;
      wave_sel_q   <= wave_sel_d;
      freq_q       <= freq_d;
      cmin_q       <= cmin_d;
      cmax_q       <= cmax_d;
      cinc_q       <= cinc_d;
      cdiv_q       <= cdiv_d;
      duty_q       <= duty_d;
      fmc_q        <= fmc_d;
      cdown_q      <= cdown_d;
      cdel_q       <= cdel_d;
      fmdev_q      <= fmdev_d;
    end
  end

  assign out_sel          = out_sel_q;
  assign wave_sel         = wave_sel_q;
  assign freq_ctrl        = freq_q;
  assign chirp_min_ctrl   = cmin_q;
  assign chirp_max_ctrl   = cmax_q;
  assign chirp_inc_rate   = cinc_q;
  assign chirp_div_rate   = cdiv_q;
  assign pulse_duty_cycle = duty_q;
  assign fm_ctr_ctrl      = fmc_q;
  assign chirp_is_down    = cdown_q;
  assign chirp_delay      = cdel_q;
  assign fm_deviation     = fmdev_q;
  assign cfg_update       = cfg_update_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_mawg_cfg_ctrl.sv
// Bench for mawg_cfg_ctrl: directed frames with literal expectations plus
// randomized frames, gaps and resets, all checked every cycle against a
// byte-queue model of the framing rules.
module tb_mawg_cfg_ctrl;

  localparam int TMO = 40;
`ifdef MAWG_CFG_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_busy = 1'b0;
  logic [1:0]  out_sel, wave_sel;
  logic [31:0] freq_ctrl, chirp_min_ctrl, chirp_max_ctrl, chirp_inc_rate;
  logic [31:0] chirp_div_rate, pulse_duty_cycle, fm_ctr_ctrl;
  logic        chirp_is_down;
  logic [3:0]  chirp_delay;
  logic [4:0]  fm_deviation;
  logic        cfg_update, frame_err;

  mawg_cfg_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_busy(rx_busy),
    .out_sel(out_sel), .wave_sel(wave_sel), .freq_ctrl(freq_ctrl),
    .chirp_min_ctrl(chirp_min_ctrl), .chirp_max_ctrl(chirp_max_ctrl),
    .chirp_inc_rate(chirp_inc_rate), .chirp_div_rate(chirp_div_rate),
    .pulse_duty_cycle(pulse_duty_cycle), .fm_ctr_ctrl(fm_ctr_ctrl),
    .chirp_is_down(chirp_is_down), .chirp_delay(chirp_delay),
    .fm_deviation(fm_deviation), .cfg_update(cfg_update), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // Reference model state
  byte unsigned frame[$];
  int          gap;
  bit          m_prev;
  logic [1:0]  m_out_sel, m_wave_sel;
  logic [31:0] m_freq, m_cmin, m_cmax, m_cinc, m_cdiv, m_duty, m_fmc;
  logic        m_cdown;
  logic [3:0]  m_cdel;
  logic [4:0]  m_fmdev;
  logic        m_upd, m_err;

  task automatic model_clear_cfg();
    m_out_sel = '0; m_wave_sel = '0; m_freq = '0; m_cmin = '0; m_cmax = '0;
    m_cinc = '0; m_cdiv = '0; m_duty = '0; m_fmc = '0; m_cdown = 1'b0;
    m_cdel = '0; m_fmdev = '0;
  endtask

  task automatic model_apply();
    logic [7:0]  cmd;
    logic [31:0] w;
    bit          ok;
    cmd = frame[0];
    w   = {frame[1], frame[2], frame[3], frame[4]};
    ok  = 1'b1;
    if (FLEN == 6) ok = ((frame[0] ^ frame[1] ^ frame[2] ^ frame[3] ^ frame[4]) == frame[FLEN-1]);
    if (!ok || (cmd > 8'h0F) || (cmd inside {8'h0C, 8'h0D, 8'h0E})) begin
      m_err = 1'b1;
    end else begin
      m_upd = 1'b1;
      case (cmd)
        8'h00: m_out_sel  = w[1:0];
        8'h01: m_wave_sel = w[1:0];
        8'h02: m_freq     = w;
        8'h03: m_cdown    = w[0];
        8'h04: m_cdel     = w[3:0];
        8'h05: m_cmin     = w;
        8'h06: m_cmax     = w;
        8'h07: m_cdiv     = w;
        8'h08: m_cinc     = w;
        8'h09: m_duty     = w;
        8'h0A: m_fmc      = w;
        8'h0B: m_fmdev    = w[4:0];
        default: model_clear_cfg();
      endcase
    end
  endtask

  task automatic model_step();
    bit strobe;
    strobe = m_prev && !rx_busy;
    m_prev = rx_busy;
    m_upd  = 1'b0;
    m_err  = 1'b0;
    if (frame.size() > 0 && gap == TMO) begin
      frame.delete();
      m_err = 1'b1;
      gap   = 0;
    end else if (frame.size() > 0 && !strobe) begin
      gap++;
    end
    if (strobe) begin
      frame.push_back(rx_data);
      gap = 0;
      if (frame.size() == FLEN) begin
        model_apply();
        frame.delete();
      end
    end
  endtask

  task automatic monitor();
    logic [239:0] d, m;
    forever begin
      @(posedge clk);
      if (!rst) begin
        frame.delete(); gap = 0; m_prev = 1'b0; m_upd = 1'b0; m_err = 1'b0;
        model_clear_cfg();
      end else begin
        model_step();
      end
      #1;
      d = {out_sel, wave_sel, freq_ctrl, chirp_min_ctrl, chirp_max_ctrl,
           chirp_inc_rate, chirp_div_rate, pulse_duty_cycle, fm_ctr_ctrl,
           chirp_is_down, chirp_delay, fm_deviation, cfg_update, frame_err};
      m = {m_out_sel, m_wave_sel, m_freq, m_cmin, m_cmax, m_cinc, m_cdiv,
           m_duty, m_fmc, m_cdown, m_cdel, m_fmdev, m_upd, m_err};
      n_vec++;
      if (d !== m) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, d, m);
      end
      if (cfg_update === 1'b1) upd_seen++;
      if (frame_err === 1'b1) err_seen++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_cyc);
    @(negedge clk);
    rx_busy = 1'b1;
    rx_data = b;
    repeat (2) @(negedge clk);
    rx_busy = 1'b0;
    repeat (gap_cyc) @(negedge clk);
  endtask

  function automatic int pick_gap(input bit rnd);
    int r;
    if (!rnd) return 1;
    r = int'($urandom_range(0, 99));
    if (r < 4) return TMO - 3 + int'($urandom_range(0, 5));
    return int'($urandom_range(0, 3));
  endfunction

  // Data bytes (and checksum when enabled) following an already-sent cmd.
  task automatic send_tail(input logic [7:0] cmd, input logic [31:0] w,
                           input bit bad_cs, input bit rnd);
    logic [7:0] cs;
    cs = cmd ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    send_byte(w[31:24], pick_gap(rnd));
    send_byte(w[23:16], pick_gap(rnd));
    send_byte(w[15:8],  pick_gap(rnd));
`ifdef MAWG_CFG_CHECKSUM_EN
    send_byte(w[7:0],   pick_gap(rnd));
    send_byte(cs ^ {7'd0, bad_cs}, 3);
`else
    if (bad_cs) cs = 8'h00;
    send_byte(w[7:0], 3);
`endif
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] w,
                            input bit bad_cs, input bit rnd);
    send_byte(cmd, pick_gap(rnd));
    send_tail(cmd, w, bad_cs, rnd);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, e0;
    frame.delete(); gap = 0; m_prev = 1'b0; m_upd = 1'b0; m_err = 1'b0;
    model_clear_cfg();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_freq", freq_ctrl, 32'h0);
    check("reset_flags", {30'd0, cfg_update, frame_err}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // freq_ctrl write, single pulse
    u0 = upd_seen;
    send_frame(8'h02, 32'h0001_0000, 1'b0, 1'b0);
    check("f025_freq", freq_ctrl, 32'h0001_0000);
    check("f025_model", m_freq, 32'h0001_0000);
    check("f025_pulses", upd_seen - u0, 1);
    check("f025_others", {30'd0, out_sel}, 32'h0);

    // fm_deviation truncation, then clear-all
    send_frame(8'h0B, 32'h0000_003F, 1'b0, 1'b0);
    check("f026_fmdev", {27'd0, fm_deviation}, 32'h1F);
    u0 = upd_seen;
    send_frame(8'h0F, 32'h0000_0000, 1'b0, 1'b0);
    check("f026_clr_freq", freq_ctrl, 32'h0);
    check("f026_clr_fmdev", {27'd0, fm_deviation}, 32'h0);
    check("f026_pulse", upd_seen - u0, 1);

    // timeout abort of partial frame
    send_frame(8'h02, 32'h0000_A5A5, 1'b0, 1'b0);
    e0 = err_seen;
    send_byte(8'h02, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    repeat (TMO + 5) @(negedge clk);
    check("f027_err", err_seen - e0, 1);
    check("f027_freq", freq_ctrl, 32'h0000_A5A5);
    send_frame(8'h01, 32'h0000_0002, 1'b0, 1'b0);
    check("f027_wave", {30'd0, wave_sel}, 32'h2);

    // reserved command
    u0 = upd_seen; e0 = err_seen;
    send_frame(8'h0D, 32'h1122_3344, 1'b0, 1'b0);
    check("f028_err", err_seen - e0, 1);
    check("f028_noupd", upd_seen - u0, 0);
    check("f028_freq", freq_ctrl, 32'h0000_A5A5);

    // byte landing exactly on the timeout cycle becomes the new cmd
    e0 = err_seen;
    send_byte(8'h02, 0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h03, 1);
    send_tail(8'h03, 32'h0000_0001, 1'b0, 1'b0);
    check("f019_err", err_seen - e0, 1);
    check("f019_cdown", {31'd0, chirp_is_down}, 32'h1);
    check("f019_model", {31'd0, m_cdown}, 32'h1);

    // reset mid-frame
    send_byte(8'h02, 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("f029_freq", freq_ctrl, 32'h0);
    check("f029_wave", {30'd0, wave_sel}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h09, 32'h0000_8000, 1'b0, 1'b0);
    check("f029_duty", pulse_duty_cycle, 32'h0000_8000);
    check("f029_freq2", freq_ctrl, 32'h0);

`ifdef MAWG_CFG_CHECKSUM_EN
    send_frame(8'h02, 32'h0000_0010, 1'b0, 1'b0);
    check("f030_good", freq_ctrl, 32'h10);
    e0 = err_seen;
    send_frame(8'h02, 32'h0000_0010, 1'b1, 1'b0);
    check("f030_bad_err", err_seen - e0, 1);
    check("f030_bad_freq", freq_ctrl, 32'h10);
`endif

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  cmd;
      logic [31:0] w;
      int          r;
      r   = int'($urandom_range(0, 99));
      cmd = (r < 85) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      w   = $urandom;
      r   = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end else if (r < 8) begin
        send_byte(cmd, pick_gap(1'b1));
        send_byte(w[7:0], pick_gap(1'b1));
      end else begin
        send_frame(cmd, w, ($urandom_range(0, 99) < 20), 1'b1);
      end
    end
    repeat (TMO + 5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mawg_cfg_ctrl.md
MAWG_CFG_CTRL -- requirements
Module: mawg_cfg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000: number of clk cycles allowed between bytes of one frame.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data, input, 8: received UART byte, valid when rx_busy falls.
REQ-005 SHALL have port rx_busy, input, 1: UART receiver busy; a 1->0 transition marks one received byte.
REQ-006 SHALL have ports out_sel (2) and wave_sel (2), outputs: MAWG output and waveform select.
REQ-007 SHALL have ports freq_ctrl, chirp_min_ctrl, chirp_max_ctrl, chirp_inc_rate, chirp_div_rate, pulse_duty_cycle and fm_ctr_ctrl, outputs, 32 each: MAWG control words.
REQ-008 SHALL have ports chirp_is_down (1), chirp_delay (4) and fm_deviation (5), outputs: MAWG chirp and FM settings.
REQ-009 SHALL have port cfg_update, output, 1: one-cycle pulse when any config output changes from a frame.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a rejected or aborted frame.

Function
REQ-011 SHALL register rx_busy into prev_busy; byte strobe = prev_busy & ~rx_busy; prev_busy resets to 0.
REQ-012 SHALL frame as: cmd byte, then 4 data bytes MSB first, assembled into 32-bit word W.
REQ-013 SHALL implement states IDLE (await cmd), DATA (byte count 0..3), CHK (CHECKSUM_EN only); IDLE->DATA on strobe; DATA->IDLE (or CHK) after 4th data byte; CHK->IDLE on strobe.
REQ-014 SHALL write on the clk edge following the final-byte strobe: cmd 0x0 out_sel=W[1:0], 0x1 wave_sel=W[1:0], 0x2 freq_ctrl, 0x3 chirp_is_down=W[0], 0x4 chirp_delay=W[3:0], 0x5 chirp_min_ctrl, 0x6 chirp_max_ctrl, 0x7 chirp_div_rate, 0x8 chirp_inc_rate, 0x9 pulse_duty_cycle, 0xA fm_ctr_ctrl, 0xB fm_deviation=W[4:0].
REQ-015 SHALL, on cmd 0xF, clear every config output to 0 and ignore W.
REQ-016 SHALL, on cmd 0xC-0xE or >=0x10, complete framing, write nothing, and pulse frame_err instead of cfg_update.
REQ-017 SHALL assert cfg_update in the same cycle the new value first appears on the outputs; latency = 1 cycle from the final-byte strobe.
REQ-018 SHALL count idle cycles while not in IDLE, clear the count on each strobe, and on reaching TIMEOUT_CYCLES return to IDLE, discard the partial frame and pulse frame_err.
REQ-019 SHALL treat a strobe coinciding with the timeout as a new cmd byte (timeout wins, then IDLE consumes byte).
REQ-020 SHALL hold all config outputs unchanged outside of a valid frame commit.

Reset
REQ-021 SHALL, while rst=0, force state IDLE, byte count 0, W=0, timeout count 0, prev_busy=0, cfg_update=0, frame_err=0 and all config outputs 0.
REQ-022 SHALL drop any partial frame when reset asserts mid-frame; the first strobe after release is a cmd byte.

Configuration
REQ-023 SHALL, with MAWG_CFG_CHECKSUM_EN defined, require a 6th byte equal to XOR of cmd and the 4 data bytes; on mismatch write nothing and pulse frame_err; commit occurs one cycle after the checksum strobe.
REQ-024 SHALL, without MAWG_CFG_CHECKSUM_EN, use 5-byte frames and omit state CHK entirely.

Verification
REQ-025 SHALL cover: bytes 02 00 01 00 00 -> freq_ctrl=0x00010000, one cfg_update pulse, other outputs unchanged.
REQ-026 SHALL cover: bytes 0B 00 00 00 3F -> fm_deviation=5'h1F; then 0F 00 00 00 00 -> all outputs 0, cfg_update pulse.
REQ-027 SHALL cover: bytes 02 12 34, then TIMEOUT_CYCLES idle cycles -> frame_err pulse, freq_ctrl unchanged; next 01 00 00 00 02 -> wave_sel=2.
REQ-028 SHALL cover: bytes 0D 11 22 33 44 -> frame_err pulse, no cfg_update, no output change.
REQ-029 SHALL cover: rst=0 after 3rd byte of a freq_ctrl frame -> outputs 0; after release 09 00 00 80 00 -> pulse_duty_cycle=0x00008000.
REQ-030 SHALL cover (MAWG_CFG_CHECKSUM_EN): 02 00 00 00 10 12 -> freq_ctrl=0x10; 02 00 00 00 10 13 -> frame_err, freq_ctrl unchanged.
